div_32: RTL and testbench



---
 rtl/minisys_pkg.sv | 13 +
 rtl/addsub_32.sv | 22 ++
 rtl/div_32.sv | 124 ++++++++++++
 tb/tb_div_32.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/minisys_pkg.sv
// Shared constants for the minisys execute-stage blocks.
// Holds the data width and the divider state encodings and cycle count.
package minisys_pkg;

  localparam int unsigned WORD       = 32;
  localparam int unsigned DIV_CYCLES = 32;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_FIX  = 2'd2;
  localparam logic [1:0] DIV_DONE = 2'd3;

endpackage

// File: rtl/addsub_32.sv
// 32-bit adder/subtractor shared by the ALU and the divider.
// With sub_ctrl=1, cf is the borrow: 1 when a < b as unsigned values.
module addsub_32
  import minisys_pkg::*;
(
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b,
  input  logic            sub_ctrl,
  output logic [WORD-1:0] sum,
  output logic            cf
);

  logic [WORD-1:0] w_b;
  logic [WORD:0]   w_full;

  assign w_b    = sub_ctrl ? ~b : b;
  assign w_full = {1'b0, a} + {1'b0, w_b} + {{WORD{1'b0}}, sub_ctrl};
  assign sum    = w_full[WORD-1:0];
  // Carry-out of a + ~b + 1 is "no borrow", so invert it when subtracting.
  assign cf     = w_full[WORD] ^ sub_ctrl;

endmodule

// File: rtl/div_32.sv
// Sequential restoring divider for DIV/DIVU: one quotient bit per cycle,
// quotient to LO (q) and remainder to HI (r), start/busy/done handshake.
module div_32
  import minisys_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  logic [1:0]      r_state;
  logic [4:0]      r_cnt;
  logic [WORD-1:0] r_rem;
  logic [WORD-1:0] r_dvd;
  logic [WORD-1:0] r_dsr;
  logic            r_sa;
  logic            r_sb;
  logic            r_dz_pend;
  logic [WORD-1:0] r_q;
  logic [WORD-1:0] r_r;
  logic            r_busy;
  logic            r_done;
  logic            r_dz;

  logic            w_neg_a;
  logic            w_neg_b;
  logic [WORD-1:0] w_abs_a;
  logic [WORD-1:0] w_abs_b;
  logic            w_hi;
  logic [WORD-1:0] w_rem_sh;
  logic [WORD-1:0] w_trial;
  logic            w_cf;
  logic            w_take;

  assign w_neg_a = signed_ctrl & a[WORD-1];
  assign w_neg_b = signed_ctrl & b[WORD-1];
  assign w_abs_a = w_neg_a ? -a : a;
  assign w_abs_b = w_neg_b ? -b : b;

  // The bit shifted out of rem makes the 33-bit partial remainder exceed any divisor.
  assign w_hi     = r_rem[WORD-1];
  assign w_rem_sh = {r_rem[WORD-2:0], r_dvd[WORD-1]};
  assign w_take   = w_hi | ~w_cf;

  addsub_32 u_addsub (
    .a        (w_rem_sh),
    .b        (r_dsr),
    .sub_ctrl (1'b1),
    .sum      (w_trial),
    .cf       (w_cf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= DIV_IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_dsr     <= '0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_dz_pend <= 1'b0;
      r_q       <= '0;
      r_r       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
    end else begin
      case (r_state)
        // DONE samples start like IDLE so a held start repeats every 34 cycles.
        DIV_IDLE, DIV_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_rem     <= '0;
            r_dvd     <= w_abs_a;
            r_dsr     <= w_abs_b;
            r_sa      <= w_neg_a;
            r_sb      <= w_neg_b;
            r_dz_pend <= (b == '0);
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= DIV_CALC;
          end else begin
            r_busy  <= 1'b0;
            r_state <= DIV_IDLE;
          end
        end
        DIV_CALC: begin
          r_rem <= w_take ? w_trial : w_rem_sh;
          r_dvd <= {r_dvd[WORD-2:0], w_take};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'(DIV_CYCLES - 1)) begin
            r_state <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          r_q     <= (r_sa ^ r_sb) ? -r_dvd : r_dvd;
          r_r     <= r_sa ? -r_rem : r_rem;
          r_dz    <= r_dz_pend;
          r_done  <= 1'b1;
          r_state <= DIV_DONE;
        end
        default: r_state <= DIV_IDLE;
      endcase
    end
  end

  assign q    = r_q;
  assign r    = r_r;
  assign busy = r_busy;
  assign done = r_done;
  assign dz   = r_dz;

endmodule

// File: tb/tb_div_32.sv
// Directed-vector bench for div_32: results, latency, handshake and reset.
module tb_div_32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        done;
  logic        dz;

  int unsigned n_checks;
  int unsigned n_errors;

  div_32 #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_ctrl (signed_ctrl),
    .a           (a),
    .b           (b),
    .q           (q),
    .r           (r),
    .busy        (busy),
    .done        (done),
    .dz          (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one division, checks busy, the done latency, the result and its hold.
  task automatic run_div(input string tag, input logic sg, input logic [31:0] ia,
                         input logic [31:0] ib, input logic [31:0] eq,
                         input logic [31:0] er, input logic edz);
    int unsigned n;
    start = 1'b1; signed_ctrl = sg; a = ia; b = ib;
    tick();
    start = 1'b0; a = 32'h0BAD_0BAD; b = 32'h0000_0003; signed_ctrl = ~sg;
    check({tag, ".busy"}, {31'b0, busy}, 32'd1);
    n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    check({tag, ".latency"}, n, 32'd33);
    check({tag, ".q"}, q, eq);
    check({tag, ".r"}, r, er);
    check({tag, ".dz"}, {31'b0, dz}, {31'b0, edz});
    tick();
    check({tag, ".done_fall"}, {31'b0, done}, 32'd0);
    check({tag, ".busy_fall"}, {31'b0, busy}, 32'd0);
    tick();
    check({tag, ".q_hold"}, q, eq);
  endtask

  initial begin
    int unsigned n;
    int unsigned d1;
    int unsigned d2;
    int unsigned nd;
    int unsigned cyc;
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; start = 1'b0; signed_ctrl = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    check("rst.q", q, 32'd0);
    check("rst.r", r, 32'd0);
    check("rst.busy", {31'b0, busy}, 32'd0);
    check("rst.done", {31'b0, done}, 32'd0);
    check("rst.dz", {31'b0, dz}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_div("u100d7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_div("sm7d2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_div("s7dm2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run_div("umaxd1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_div("uhi", 1'b0, 32'h8000_0001, 32'h8000_0000, 32'd1, 32'd1, 1'b0);
    run_div("udz", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run_div("sovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run_div("u1000d10", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);

    // start pulsed mid-operation must be ignored
    start = 1'b1; signed_ctrl = 1'b0; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    repeat (9) tick();
    start = 1'b1; a = 32'd50; b = 32'd5;
    tick();
    start = 1'b0;
    n = 10;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    check("ign.latency", n, 32'd33);
    check("ign.q", q, 32'd14);
    check("ign.r", r, 32'd2);
    repeat (2) tick();
    check("ign.idle", {31'b0, busy}, 32'd0);

    // start held high gives back-to-back results
    start = 1'b1; signed_ctrl = 1'b0; a = 32'd1000; b = 32'd7;
    d1 = 0; d2 = 0; nd = 0; cyc = 0;
    while (nd < 2 && cyc < 200) begin
      tick();
      cyc++;
      if (done) begin
        if (nd == 0) d1 = cyc; else d2 = cyc;
        nd++;
        check("b2b.q", q, 32'd142);
        check("b2b.r", r, 32'd6);
        check("b2b.busy", {31'b0, busy}, 32'd1);
      end
    end
    check("b2b.count", nd, 32'd2);
    check("b2b.period", d2 - d1, 32'd34);
    start = 1'b0;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    check("b2b.drain", {31'b0, busy}, 32'd0);

    // reset in the middle of CALC: outputs clear at once, no done afterwards
    start = 1'b1; signed_ctrl = 1'b0; a = 32'd77; b = 32'd4;
    tick();
    start = 1'b0;
    repeat (15) tick();
    rst_n = 1'b0;
    #1;
    check("mrst.q", q, 32'd0);
    check("mrst.r", r, 32'd0);
    check("mrst.busy", {31'b0, busy}, 32'd0);
    check("mrst.done", {31'b0, done}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      tick();
      if (done || busy) nd++;
    end
    check("mrst.no_done", nd, 32'd0);
    run_div("post_rst", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
